// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: FSM state encodings and the
// default word width. The PARITY state only exists when
// BYTE_SERIALIZER_PARITY_EN is defined.
package byte_serializer_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef BYTE_SERIALIZER_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/byte_serializer_bit_counter.sv
// Bit position counter for the serializer. Cleared asynchronously by reset
// and synchronously when a new word is accepted; advances once per bit taken.
// tc flags the last data bit (count == WIDTH-1).
module byte_serializer_bit_counter
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CW   = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  // count bits taken; a fresh word restarts at zero
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/byte_serializer.sv
// Parallel-in/serial-out stage. Accepts a word on load while ready, then
// presents one bit per cycle on sout (qualified by svalid) and advances on
// each sen-high edge. done pulses the cycle after the final bit is taken,
// and ready is already high in that cycle so words can run back to back.
// Optional build macro BYTE_SERIALIZER_PARITY_EN appends an even-parity bit.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [1:WIDTH] d,
  input  logic           load,
  output logic           ready,
  input  logic           sen,
  output logic           sout,
  output logic           svalid,
  output logic           done
);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] dn;
  logic             tc;
  logic             accept;
  logic             take;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic             par;
`endif

  assign accept = (state == ST_IDLE) && load;
  assign take   = (state == ST_SHIFT) && sen;

  // reorder the input so the first bit to send lands at sreg[WIDTH-1]
  always_comb begin
    dn = d;
    if (!MSB_FIRST)
      for (int i = 0; i < WIDTH; i++) dn[i] = d[i+1];
  end

  // shift register: load on accept, move next bit to the head on each take
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       sreg <= '0;
    else if (accept) sreg <= dn;
    else if (take)   sreg <= {sreg[WIDTH-2:0], 1'b0};
  end

`ifdef BYTE_SERIALIZER_PARITY_EN
  // even parity of the captured word, sent after the data bits
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       par <= 1'b0;
    else if (accept) par <= ^d;
  end
`endif

  byte_serializer_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .nrst (nrst),
    .clr  (accept),
    .en   (take),
    .tc   (tc)
  );

  // control FSM with registered ready/svalid/done
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= ST_IDLE;
      ready  <= 1'b1;
      svalid <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            state  <= ST_SHIFT;
            ready  <= 1'b0;
            svalid <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (sen && tc) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
            state  <= ST_PARITY;
`else
            state  <= ST_IDLE;
            ready  <= 1'b1;
            svalid <= 1'b0;
            done   <= 1'b1;
`endif
          end
        end
`ifdef BYTE_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (sen) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            svalid <= 1'b0;
            done   <= 1'b1;
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          ready  <= 1'b1;
          svalid <= 1'b0;
        end
      endcase
    end
  end

  // serial output: head of the shift register, parity bit, or 0 when idle
  always_comb begin
    sout = 1'b0;
    case (state)
      ST_SHIFT:  sout = sreg[WIDTH-1];
`ifdef BYTE_SERIALIZER_PARITY_EN
      ST_PARITY: sout = par;
`endif
      default:   sout = 1'b0;
    endcase
  end

endmodule
